// File: rtl/cmp_cmd_queue.sv
// Command FIFO in front of the mini comparator: buffers (sel, a, b) commands,
// drives the head entry to the comparator and returns tagged, registered results.
module cmp_cmd_queue #(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   parameter int TAGW  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_sel,
   input  logic [N-1:0]               in_a,
   input  logic [N-1:0]               in_b,
   output logic [2:0]                 cmp_sel,
   output logic [N-1:0]               cmp_value1,
   output logic [N-1:0]               cmp_value2,
   input  logic                       cmp_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       res_bit,
   output logic [TAGW-1:0]            res_tag,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                true_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [2:0]      sel_mem [DEPTH];
   logic [N-1:0]    a_mem   [DEPTH];
   logic [N-1:0]    b_mem   [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [TAGW-1:0] tag_cnt;
   logic            push;
   logic            fire;
   logic            empty;

   assign empty    = (level == '0);
   assign in_ready = (level != LW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign fire     = !empty && (!res_valid || res_ready);

   assign cmp_sel    = empty ? 3'b000 : sel_mem[rd_ptr];
   assign cmp_value1 = empty ? '0     : a_mem[rd_ptr];
   assign cmp_value2 = empty ? '0     : b_mem[rd_ptr];

   // Storage array carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         sel_mem[wr_ptr] <= in_sel;
         a_mem[wr_ptr]   <= in_a;
         b_mem[wr_ptr]   <= in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         tag_cnt   <= '0;
         res_valid <= 1'b0;
         res_bit   <= 1'b0;
         res_tag   <= '0;
         true_cnt  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (fire)
            rd_ptr <= rd_ptr + AW'(1);

         if (push && !fire)
            level <= level + LW'(1);
         else if (fire && !push)
            level <= level - LW'(1);

         // A new result may replace one being handed off in the same cycle.
         if (fire) begin
            res_bit   <= cmp_out;
            res_tag   <= tag_cnt;
            tag_cnt   <= tag_cnt + TAGW'(1);
            res_valid <= 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         if (res_valid && res_ready && res_bit && (true_cnt != 16'hFFFF))
            true_cnt <= true_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_cmp_cmd_queue.sv
// Directed self-checking bench for cmp_cmd_queue with a behavioural comparator.
module tb_cmp_cmd_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_sel;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [2:0]  cmp_sel;
   logic [7:0]  cmp_value1;
   logic [7:0]  cmp_value2;
   logic        cmp_out;
   logic        res_valid;
   logic        res_ready;
   logic        res_bit;
   logic [7:0]  res_tag;
   logic [2:0]  level;
   logic [15:0] true_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_cmd_queue #(.N(8), .DEPTH(4), .TAGW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_a       (in_a),
      .in_b       (in_b),
      .cmp_sel    (cmp_sel),
      .cmp_value1 (cmp_value1),
      .cmp_value2 (cmp_value2),
      .cmp_out    (cmp_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_bit    (res_bit),
      .res_tag    (res_tag),
      .level      (level),
      .true_cnt   (true_cnt)
   );

   // Unsigned mini comparator.
   always_comb begin
      cmp_out = 1'b0;
      case (cmp_sel)
         3'b000: cmp_out = 1'b0;
         3'b001: cmp_out = 1'b1;
         3'b010: cmp_out = (cmp_value1 == cmp_value2);
         3'b011: cmp_out = (cmp_value1 != cmp_value2);
         3'b100: cmp_out = (cmp_value1 >= cmp_value2);
         3'b101: cmp_out = (cmp_value1 <= cmp_value2);
         3'b110: cmp_out = (cmp_value1 <  cmp_value2);
         default: cmp_out = (cmp_value1 > cmp_value2);
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      in_valid = v;
      in_sel   = s;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [7:0] exp_bits;

   initial begin
      rst_n     = 1'b0;
      res_ready = 1'b0;
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      exp_bits = 8'b0110_1010;
      tick();
      do_reset();

      check_output("rst_level",  32'(level),      32'd0);
      check_output("rst_rvalid", 32'(res_valid),  32'd0);
      check_output("rst_ready",  32'(in_ready),   32'd1);
      check_output("rst_bit",    32'(res_bit),    32'd0);
      check_output("rst_tag",    32'(res_tag),    32'd0);
      check_output("rst_tcnt",   32'(true_cnt),   32'd0);
      check_output("rst_csel",   32'(cmp_sel),    32'd0);
      check_output("rst_cv1",    32'(cmp_value1), 32'd0);
      check_output("rst_cv2",    32'(cmp_value2), 32'd0);

      // Single eq command
      res_ready = 1'b1;
      apply_stimulus(1'b1, 3'b010, 8'h5A, 8'h5A);
      tick();
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      check_output("t1_level", 32'(level),      32'd1);
      check_output("t1_csel",  32'(cmp_sel),    32'd2);
      check_output("t1_cv1",   32'(cmp_value1), 32'h5A);
      check_output("t1_cv2",   32'(cmp_value2), 32'h5A);
      check_output("t1_rv0",   32'(res_valid),  32'd0);
      tick();
      check_output("t1_rv1",   32'(res_valid),  32'd1);
      check_output("t1_bit",   32'(res_bit),    32'd1);
      check_output("t1_tag",   32'(res_tag),    32'd0);
      check_output("t1_level0",32'(level),      32'd0);
      tick();
      check_output("t1_rv2",   32'(res_valid),  32'd0);
      check_output("t1_tcnt",  32'(true_cnt),   32'd1);

      // Eight back-to-back commands, every select code
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 3'(i), 8'h10, 8'h20);
         tick();
         check_output("t2_level", 32'(level), 32'd1);
         if (i > 0) begin
            check_output("t2_rv",  32'(res_valid), 32'd1);
            check_output("t2_bit", 32'(res_bit),   32'(exp_bits[i-1]));
            check_output("t2_tag", 32'(res_tag),   32'(i-1));
         end
      end
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      check_output("t2_rv7",  32'(res_valid), 32'd1);
      check_output("t2_bit7", 32'(res_bit),   32'd0);
      check_output("t2_tag7", 32'(res_tag),   32'd7);
      tick();
      check_output("t2_rvend", 32'(res_valid), 32'd0);
      check_output("t2_tcnt",  32'(true_cnt),  32'd4);

      // Fill with consumer stalled: ge against 2 gives 0,0,1,1,1,1
      do_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 3'b100, 8'(i), 8'h02);
         tick();
      end
      check_output("t3_level", 32'(level),     32'd4);
      check_output("t3_ready", 32'(in_ready),  32'd0);
      check_output("t3_rv",    32'(res_valid), 32'd1);
      check_output("t3_bit",   32'(res_bit),   32'd0);
      check_output("t3_tag",   32'(res_tag),   32'd0);
      apply_stimulus(1'b1, 3'b100, 8'h05, 8'h02);
      tick();
      tick();
      check_output("t3_hlevel", 32'(level),    32'd4);
      check_output("t3_hbit",   32'(res_bit),  32'd0);
      check_output("t3_htag",   32'(res_tag),  32'd0);
      check_output("t3_hready", 32'(in_ready), 32'd0);

      // Drain from full with producer still pushing
      res_ready = 1'b1;
      #1;
      check_output("t4_noready", 32'(in_ready), 32'd0);
      tick();
      check_output("t4_level1", 32'(level),    32'd3);
      check_output("t4_tag1",   32'(res_tag),  32'd1);
      check_output("t4_bit1",   32'(res_bit),  32'd0);
      check_output("t4_ready1", 32'(in_ready), 32'd1);
      tick();
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      check_output("t4_level2", 32'(level),   32'd3);
      check_output("t4_tag2",   32'(res_tag), 32'd2);
      check_output("t4_bit2",   32'(res_bit), 32'd1);
      for (int k = 3; k < 6; k++) begin
         tick();
         check_output("t4_tagk",   32'(res_tag),   32'(k));
         check_output("t4_bitk",   32'(res_bit),   32'd1);
         check_output("t4_levelk", 32'(level),     32'(5-k));
         check_output("t4_rvk",    32'(res_valid), 32'd1);
      end
      tick();
      check_output("t4_rvend", 32'(res_valid), 32'd0);
      check_output("t4_tcnt",  32'(true_cnt),  32'd4);

      // 260 true commands: tag wraps
      do_reset();
      res_ready = 1'b1;
      for (int k = 1; k <= 260; k++) begin
         apply_stimulus(1'b1, 3'b001, 8'h00, 8'h00);
         tick();
         if (k == 257) check_output("t5_tag255", 32'(res_tag), 32'd255);
         if (k == 258) check_output("t5_tag0",   32'(res_tag), 32'd0);
      end
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      check_output("t5_taglast", 32'(res_tag), 32'd3);
      tick();
      check_output("t5_tcnt", 32'(true_cnt), 32'd260);

      // Saturation of true_cnt
      do_reset();
      for (int k = 1; k <= 65540; k++) begin
         apply_stimulus(1'b1, 3'b001, 8'h00, 8'h00);
         tick();
         if (k == 65536) check_output("t6_fffe", 32'(true_cnt), 32'hFFFE);
      end
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      tick();
      tick();
      check_output("t6_sat", 32'(true_cnt), 32'hFFFF);

      // Reset in the middle of operation
      do_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 3'b001, 8'(i), 8'h00);
         tick();
      end
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      check_output("t7_prelevel", 32'(level),     32'd3);
      check_output("t7_prerv",    32'(res_valid), 32'd1);
      do_reset();
      check_output("t7_level", 32'(level),     32'd0);
      check_output("t7_rv",    32'(res_valid), 32'd0);
      check_output("t7_ready", 32'(in_ready),  32'd1);
      res_ready = 1'b1;
      apply_stimulus(1'b1, 3'b001, 8'h00, 8'h00);
      tick();
      apply_stimulus(1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      check_output("t7_rv1",  32'(res_valid), 32'd1);
      check_output("t7_tag",  32'(res_tag),   32'd0);
      check_output("t7_bit",  32'(res_bit),   32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_cmd_queue.md
Name: cmp_cmd_queue

Overview:
- Command-buffering stage that sits directly upstream of the mini comparator.
- Accepts compare commands (select code plus two operands) over a valid/ready interface and holds them in a small FIFO.
- Presents the head command to the combinational comparator and registers its 1-bit result.
- Returns each result with a sequence tag over a valid/ready output, decoupling bursty producers from result consumers.

Parameters:
- N, 8, operand width; must match the comparator's N.
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAGW, 8, result sequence tag width.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  FIFO can accept a command
- in_sel  in  3  compare select code (000 false, 001 true, 010 eq, 011 ne, 100 ge, 101 le, 110 lt, 111 gt)
- in_a  in  N  operand 1
- in_b  in  N  operand 2
- cmp_sel  out  3  to comparator SEL
- cmp_value1  out  N  to comparator value1
- cmp_value2  out  N  to comparator value2
- cmp_out  in  1  comparator OUT (combinational in the same cycle)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_bit  out  1  registered compare result
- res_tag  out  TAGW  sequence number of the command that produced res_bit
- level  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- true_cnt  out  16  count of delivered results equal to 1, saturating

Behaviour:
- Reset (rst_n=0 at rising edge):
  - FIFO is emptied and read/write pointers clear.
  - level=0, res_valid=0, res_bit=0, res_tag=0, true_cnt=0, internal tag counter=0.
  - Reset mid-operation discards all queued commands and any pending result.
- Push: in_ready = (level != DEPTH). A push occurs when in_valid && in_ready.
  - At full, in_ready=0 even if a pop happens the same cycle. There is no full-bypass.
- Comparator drive:
  - When level>0, cmp_sel/cmp_value1/cmp_value2 carry the head entry combinationally.
  - When empty, all three are driven to 0.
- Issue/pop: fire = (level>0) && (!res_valid || res_ready). On fire:
  - The head entry pops.
  - res_bit <= cmp_out, res_tag <= tag counter, tag counter += 1 (wraps 2^TAGW-1 -> 0).
  - res_valid <= 1.
- If res_valid && res_ready && no fire, then res_valid <= 0.
- Holding: while res_valid && !res_ready, res_bit and res_tag hold stable and the FIFO does not pop.
- Simultaneous push and pop: level is unchanged and pointers both advance. Pointers wrap modulo DEPTH.
- Latency: a command accepted at edge t appears at the head after t. Its result is registered at edge t+1, so res_valid is high in the cycle after that edge.
  - Minimum latency is 2 edges from acceptance to result.
  - Sustained throughput is 1 result per cycle when res_ready=1.
- true_cnt increments on each result handshake (res_valid && res_ready) with res_bit=1. It holds at 16'hFFFF.
- Commands are delivered in order with no reordering or dropping.

Test Plan:
- Reset then single command sel=010, a=8'h5A, b=8'h5A with res_ready=1 -> res_valid for 1 cycle, res_bit=1, res_tag=0, true_cnt=1.
- Back-to-back 8 commands cycling sel 000..111 with a=8'h10, b=8'h20, res_ready=1 -> res_bit sequence 0,1,0,1,0,1,1,0; tags 0..7; one result per cycle; true_cnt=4.
- Hold res_ready=0, push 5 commands (DEPTH=4) -> 1 result held in the output register and 4 in the FIFO, level=4, in_ready=0. The 6th in_valid is not accepted; res_bit/res_tag stay stable.
- From a full FIFO, assert res_ready=1 and in_valid=1 together -> first cycle no push (in_ready=0). Afterwards simultaneous push/pop keeps level constant and all results drain in order.
- Issue 260 commands with sel=001 -> res_tag wraps 255 -> 0 and true_cnt=260. Separately, force 65540 true results -> true_cnt saturates at 16'hFFFF.
- Deassert rst_n for one cycle with level=3 and res_valid=1 -> next cycle level=0, res_valid=0, in_ready=1, tag restarts at 0.
